// File: rtl/matrix_fill_ctrl.sv
// Sequencer that clears one matrix_unit slot, programs its dims, then streams row-major elements into it.
// Optional element range rejection is enabled by defining MATRIX_RANGE_CHK_EN.
module matrix_fill_ctrl #(
  parameter int MAX_DIM = 5
`ifdef MATRIX_RANGE_CHK_EN
  ,
  parameter logic signed [7:0] EL_MIN = -8'sd128,
  parameter logic signed [7:0] EL_MAX = 8'sd127
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] cfg_rows,
  input  logic [2:0] cfg_cols,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic       err_dims,
  output logic       err_range,
  output logic [5:0] elem_cnt,
  output logic       mu_clear,
  output logic       mu_set_dims,
  output logic [2:0] mu_dims_r,
  output logic [2:0] mu_dims_c,
  output logic       mu_we,
  output logic [2:0] mu_w_row,
  output logic [2:0] mu_w_col,
  output logic [7:0] mu_w_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETDIM, S_FILL, S_ABORT, S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] rows_q, rows_d, cols_q, cols_d;
  logic [2:0] row_q, row_d, col_q, col_d;
  logic [5:0] cnt_q, cnt_d;
  logic       err_dims_q, err_dims_d;
  logic       dims_ok, elem_ok, last_cell;

  assign dims_ok   = (cfg_rows != 3'd0) && (cfg_rows <= 3'(MAX_DIM)) &&
                     (cfg_cols != 3'd0) && (cfg_cols <= 3'(MAX_DIM));
  assign last_cell = (row_q == rows_q - 3'd1) && (col_q == cols_q - 3'd1);

`ifdef MATRIX_RANGE_CHK_EN
  logic err_range_q, err_range_d;
  assign elem_ok   = ($signed(in_data) >= EL_MIN) && ($signed(in_data) <= EL_MAX);
  assign err_range = err_range_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_range_q <= 1'b0;
    else     err_range_q <= err_range_d;
  end
`else
  assign elem_ok   = 1'b1;
  assign err_range = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    row_d      = row_q;
    col_d      = col_q;
    cnt_d      = cnt_q;
    err_dims_d = 1'b0;
    in_ready   = 1'b0;
    mu_we      = 1'b0;
`ifdef MATRIX_RANGE_CHK_EN
    err_range_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // abort has priority over start while idle
        if (!abort && start) begin
          if (dims_ok) begin
            rows_d  = cfg_rows;
            cols_d  = cfg_cols;
            row_d   = 3'd0;
            col_d   = 3'd0;
            cnt_d   = 6'd0;
            state_d = S_CLEAR;
          end else begin
            err_dims_d = 1'b1;
          end
        end
      end
      S_CLEAR:  state_d = abort ? S_ABORT : S_SETDIM;
      S_SETDIM: state_d = abort ? S_ABORT : S_FILL;
      S_FILL: begin
        if (abort) begin
          state_d = S_ABORT;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (elem_ok) begin
              mu_we = 1'b1;
              cnt_d = cnt_q + 6'd1;
              if (col_q == cols_q - 3'd1) begin
                col_d = 3'd0;
                row_d = row_q + 3'd1;
              end else begin
                col_d = col_q + 3'd1;
              end
              if (last_cell || in_last) state_d = S_DONE;
            end else begin
`ifdef MATRIX_RANGE_CHK_EN
              err_range_d = 1'b1;
`endif
            end
          end
        end
      end
      S_ABORT: state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rows_q     <= 3'd0;
      cols_q     <= 3'd0;
      row_q      <= 3'd0;
      col_q      <= 3'd0;
      cnt_q      <= 6'd0;
      err_dims_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      row_q      <= row_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      err_dims_q <= err_dims_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err_dims    = err_dims_q;
  assign elem_cnt    = cnt_q;
  assign mu_clear    = (state_q == S_CLEAR) || (state_q == S_ABORT);
  assign mu_set_dims = (state_q == S_SETDIM);
  assign mu_dims_r   = rows_q;
  assign mu_dims_c   = cols_q;
  assign mu_w_row    = row_q;
  assign mu_w_col    = col_q;
  assign mu_w_data   = in_data;

endmodule
